// File: rtl/pc_exc_ctrl.sv
// PC / EPC holder with exception-entry sequencer (vector fetch, handler load).
// Optional PC_ALIGN_CHECK_EN raises cause 0 on misaligned committed PC writes.
module pc_exc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC_BASE = 32'd252,
  parameter logic [31:0] EPC_OFFSET   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause,
  output logic        busy,
  output logic        exc_mem_req,
  output logic [31:0] exc_mem_addr,
  output logic        exc_taken
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_d;
  logic [31:0] epc_d;
  logic [1:0]  cause_d;
  logic        busy_d;
  logic        req_d;
  logic [31:0] addr_d;
  logic        taken_d;

  logic        br_ok;
  logic        wr_acc;
  logic        exc_any;
  logic        misalign;
  logic [1:0]  cause_in;

  always_comb begin
    br_ok = 1'b0;
    unique case (branch_type)
      2'b00: br_ok = alu_zero;
      2'b01: br_ok = !alu_zero;
      2'b10: br_ok = !alu_gt;
      2'b11: br_ok = alu_gt;
    endcase
  end

  // Several causes may be raised together; the lowest code wins.
  always_comb begin
    cause_in = 2'd0;
    priority case (1'b1)
      exc_opcode:   cause_in = 2'd1;
      exc_overflow: cause_in = 2'd2;
      exc_div0:     cause_in = 2'd3;
      default:      cause_in = 2'd0;
    endcase
  end

  assign exc_any = exc_opcode | exc_overflow | exc_div0;
  assign wr_acc  = pc_write | (pc_write_cond & br_ok);

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = wr_acc & (pc_next[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc           <= RESET_PC;
      epc          <= 32'd0;
      exc_cause    <= 2'd0;
      busy         <= 1'b0;
      exc_mem_req  <= 1'b0;
      exc_mem_addr <= 32'd0;
      exc_taken    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      epc          <= epc_d;
      exc_cause    <= cause_d;
      busy         <= busy_d;
      exc_mem_req  <= req_d;
      exc_mem_addr <= addr_d;
      exc_taken    <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (exc_any || misalign) state_d = REQ;
      REQ:  if (mem_valid) state_d = LOAD;
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    pc_d    = pc;
    epc_d   = epc;
    cause_d = exc_cause;
    busy_d  = 1'b0;
    req_d   = 1'b0;
    addr_d  = 32'd0;
    taken_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_any) begin
          cause_d = cause_in;
          epc_d   = pc - EPC_OFFSET;
        end else if (misalign) begin
          cause_d = 2'd0;
          epc_d   = pc_next;
        end else if (wr_acc) begin
          pc_d = pc_next;
        end
      end
      REQ: if (mem_valid) pc_d = {24'b0, mem_rdata};
      default: ;
    endcase
    unique case (state_d)
      REQ: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
        addr_d = EXC_VEC_BASE + {30'b0, cause_d};
      end
      LOAD: begin
        busy_d  = 1'b1;
        taken_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pc_exc_ctrl.md
Name: pc_exc_ctrl

Overview:
- Program-counter stage sitting directly downstream of the PC source mux; holds the architectural PC and EPC.
- Commits the mux output on unconditional or branch-qualified writes.
- Runs the exception-entry sequence: saves EPC, fetches the handler address byte from the vector table in memory, loads PC.
- Stalls the multicycle control unit while the sequence runs.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
EXC_VEC_BASE, 32'd252, vector table base; vector address = EXC_VEC_BASE + cause
EPC_OFFSET, 32'd4, subtracted from PC when saving EPC (PC already incremented past faulting instruction)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
pc_next  input  32  candidate PC from PC source mux
pc_write  input  1  unconditional PC write request
pc_write_cond  input  1  branch-qualified PC write request
branch_type  input  2  00 BEQ, 01 BNE, 10 BLE, 11 BGT
alu_zero  input  1  ALU zero flag
alu_gt  input  1  ALU greater-than flag
exc_opcode  input  1  invalid opcode detected
exc_overflow  input  1  arithmetic overflow
exc_div0  input  1  divide by zero
mem_rdata  input  8  byte returned by memory
mem_valid  input  1  memory read data valid
pc  output  32  current program counter
epc  output  32  exception PC
exc_cause  output  2  last cause taken
busy  output  1  exception sequence in progress; control unit must stall
exc_mem_req  output  1  vector read request
exc_mem_addr  output  32  vector read address
exc_taken  output  1  one-cycle pulse when handler PC is loaded

Behaviour:
- Reset (reset==0 at rising edge):
  - pc=RESET_PC; epc=0; exc_cause=0; busy=0; exc_mem_req=0; exc_mem_addr=0; exc_taken=0.
  - State=IDLE. Reset overrides any in-flight sequence.
- Branch condition:
  - BEQ: alu_zero.
  - BNE: !alu_zero.
  - BLE: !alu_gt.
  - BGT: alu_gt.
- States: IDLE, REQ, LOAD.
- IDLE:
  - If any exc_* input is high: cause = 1 opcode, 2 overflow, 3 div0; priority opcode > overflow > div0.
    - Latch exc_cause; epc <= pc - EPC_OFFSET (mod 2^32).
    - pc is not written, even if pc_write is high in the same cycle.
    - Next state REQ.
  - Otherwise, pc <= pc_next when pc_write==1, or when pc_write_cond==1 and the condition is true.
  - pc_write has priority; the result is identical either way.
  - mem_valid is ignored.
- REQ:
  - busy=1; exc_mem_req=1; exc_mem_addr = EXC_VEC_BASE + exc_cause (held stable).
  - Wait indefinitely for mem_valid.
  - On mem_valid: pc <= {24'b0, mem_rdata}; next state LOAD.
  - pc_write, pc_write_cond and exc_* are ignored; nested exceptions are dropped.
- LOAD:
  - exc_taken=1; busy=1; exc_mem_req=0.
  - Next state IDLE unconditionally; exc_* ignored in this cycle.
- Latency: exception asserted at edge N → exc_mem_req high after edge N → with mem_valid at edge N+k, pc is updated at N+k and exc_taken is high for one cycle after it; busy clears after edge N+k+1.
- All outputs are registered; exc_mem_addr returns to 0 outside REQ.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined, in IDLE, an accepted PC write whose pc_next[1:0]!=2'b00 is not committed:
  - Exception raised with cause 0.
  - epc <= pc_next (the misaligned target).
  - Vector address EXC_VEC_BASE+0.
  - Explicit exc_* inputs take priority over the misalignment check.
- When undefined, any pc_next is written unchanged and cause 0 never occurs.

Test Plan:
- Reset low 2 cycles, then pc_write=1, pc_next=32'h0000_0010 → pc=0 during reset; pc=32'h10 one edge after the write; busy=0.
- pc=32'h20, pc_write_cond=1, branch_type=01, alu_zero=1, pc_next=32'h40 → pc stays 32'h20. Repeat with alu_zero=0 → pc=32'h40.
- pc=32'h0000_0108, exc_overflow=1 and exc_div0=1 together with pc_write=1 → epc=32'h104, exc_cause=2, pc unchanged, exc_mem_req=1, exc_mem_addr=254. Apply mem_valid after 3 cycles with mem_rdata=8'h8C → pc=32'h8C, exc_taken single pulse, busy low afterward.
- exc_opcode pulse during REQ → ignored: exc_cause and epc keep first-exception values.
- reset asserted while in REQ → all outputs return to reset values next edge; mem_valid afterwards has no effect.
- (PC_ALIGN_CHECK_EN) pc_write=1, pc_next=32'h0000_0042 → pc unchanged, epc=32'h42, exc_cause=0, exc_mem_addr=252.
